nn_layer_sequencer: RTL and testbench
=====================================

Name: nn_layer_sequencer

Overview:
- Hardware scheduler that runs a full multi-layer NN inference without per-command CPU intervention.
- Holds a small per-layer descriptor table written by software through the NN register interface.
- On start, walks the layers in order. For each layer it issues three one-cycle command pulses (load bias, load weight, run layer) to the NN datapath and waits for the datapath's done handshake after each one.
- Sits between the NN register block and the NN datapath. It produces the datapath's cmd/bias/weight/channel/compensation/layer inputs.

Parameters:
- MAX_LAYERS, 8: descriptor table depth; also the upper limit on num_layers.
- LW, 3: layer index width, clog2(MAX_LAYERS).
- TIMEOUT_CYCLES, 1048576: cycles allowed in one WAIT before an error is flagged.

Ports:
- HCLK  in  1  single clock
- HRESETn  in  1  asynchronous active-low reset
- desc_we  in  1  descriptor write strobe
- desc_idx  in  LW  layer entry being written
- desc_field  in  3  field select: 0 bias_addr, 1 weight_addr, 2 in_ch, 3 out_ch, 4 compensation; values 5-7 are ignored
- desc_wdata  in  32  write data
- num_layers  in  LW+1  number of layers to run, sampled at start
- start  in  1  one-cycle pulse that begins a run
- abort  in  1  one-cycle pulse that cancels a run
- cmd_done  in  1  one-cycle pulse from the datapath: the current command has finished
- cmd  out  8  command code; one-cycle pulse, CMD_NONE otherwise
- bias_addr, weight_addr, in_ch, out_ch, compensation  out  32 each  configuration for the current layer
- layer  out  32  current layer index, zero-extended
- busy  out  1  a run is in progress
- done  out  1  one-cycle pulse when a run completes
- err  out  1  sticky error flag
- err_code  out  2  0 none, 1 timeout, 2 bad num_layers, 3 aborted

Behaviour:
- Reset values:
  - All outputs are 0; cmd = CMD_NONE.
  - Descriptor table contents are 0.
  - FSM is in IDLE.
- Descriptor writes:
  - Accepted in every state.
  - Take effect at the next HCLK edge.
- FSM states: IDLE, LOAD, ISSUE, WAIT, FIN.
- IDLE:
  - On start: clear err/err_code and capture num_layers.
  - num_layers == 0 → FIN. No commands are issued.
  - num_layers > MAX_LAYERS → stay IDLE; err = 1, err_code = 2.
  - Otherwise → LOAD with layer = 0 and phase = 0.
- LOAD:
  - Latch the descriptor entry for the current layer into the config output registers; set layer.
  - → ISSUE.
  - Config outputs stay stable for all three phases of that layer. A descriptor write during a run therefore affects only layers not yet loaded.
- ISSUE:
  - Registered cmd output is high for exactly 1 cycle.
  - Code by phase: phase 0 = CMD_LOAD_BIAS, 1 = CMD_LOAD_WEIGHT, 2 = CMD_RUN_LAYER.
  - Clear the timeout counter.
  - → WAIT.
- WAIT:
  - The timeout counter increments every cycle.
  - On cmd_done:
    - phase < 2 → phase + 1, then ISSUE.
    - phase == 2 and layer + 1 < captured num_layers → layer + 1, phase = 0, then LOAD.
    - Otherwise → FIN.
  - When the counter reaches TIMEOUT_CYCLES - 1 without cmd_done: err = 1, err_code = 1, → IDLE.
  - If cmd_done and timeout expiry fall in the same cycle, cmd_done wins.
- FIN: done = 1 for 1 cycle, then → IDLE.
- Latency:
  - start sampled at edge k → first cmd pulse visible in cycle k+2.
  - cmd_done sampled at edge j → next cmd visible in cycle j+1 (same layer) or j+2 (next layer).
- busy is 1 in every state except IDLE.
- cmd_done is ignored outside WAIT.
- start is ignored while busy.
- abort:
  - Any non-IDLE state → IDLE at the next edge.
  - err = 1, err_code = 3; cmd forced to CMD_NONE; no done pulse.
  - abort in IDLE has no effect.
  - If start and abort arrive together, abort wins.
- Asynchronous reset mid-run returns everything to the reset values immediately. The descriptor table is cleared too.
- err holds until the next accepted start.

Decomposition:
- Shared package NN_defs.vh gains: CMD_NONE 8'h00, CMD_LOAD_BIAS 8'h03, CMD_LOAD_WEIGHT 8'h04, CMD_RUN_LAYER 8'h05, the field-select constants, and the err_code constants.
- One sub-module, nn_desc_table:
  - MAX_LAYERS × 5 × 32-bit register file.
  - Synchronous write port.
  - Asynchronous whole-entry read port indexed by layer.
- The FSM, counters and output registers stay in nn_layer_sequencer.

Test Plan:
- Two-layer run, with cmd_done returned 5 cycles after each cmd:
  - Setup: entry0 = {0x100, 0x200, 16, 32, 7}, entry1 = {0x300, 0x400, 32, 8, 9}; num_layers = 2.
  - Required cmd sequence: 03, 04, 05, 03, 04, 05.
  - Config outputs show entry0 during layer 0 and entry1 during layer 1.
  - Exactly one done pulse, in the cycle after the last cmd_done; busy then drops.
- num_layers = 0, then start: no cmd pulses; done pulses once in cycle k+1; err = 0.
- num_layers = 9, then start: stays IDLE, busy never rises, err = 1, err_code = 2.
- Timeout, run with TIMEOUT_CYCLES = 16 and cmd_done never returned:
  - After the first cmd, exactly 16 cycles later: err = 1, err_code = 1, busy = 0.
  - Second case: cmd_done in the same cycle as expiry continues normally.
- abort in WAIT during layer 1, phase 1: the next edge gives IDLE, cmd = 00, err_code = 3, no done pulse. A subsequent start clears err and runs from layer 0.
- Descriptor write to entry1 bias_addr = 0xABC during layer 0 → layer 1 shows 0xABC.
- Descriptor write to entry0 during layer 0 → no change on the outputs.
- start pulsed while busy → ignored: the command sequence is unchanged.

Source files
------------

// File: rtl/nn_layer_sequencer_pkg.sv
// Shared definitions for the NN layer sequencer: command codes, descriptor
// field selects, error codes, FSM states and the descriptor entry layout.
package nn_layer_sequencer_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CMD_W   = 8;
  localparam int unsigned FIELD_W = 3;

  localparam logic [CMD_W-1:0] CMD_NONE        = 8'h00;
  localparam logic [CMD_W-1:0] CMD_LOAD_BIAS   = 8'h03;
  localparam logic [CMD_W-1:0] CMD_LOAD_WEIGHT = 8'h04;
  localparam logic [CMD_W-1:0] CMD_RUN_LAYER   = 8'h05;

  localparam logic [FIELD_W-1:0] FLD_BIAS_ADDR   = 3'd0;
  localparam logic [FIELD_W-1:0] FLD_WEIGHT_ADDR = 3'd1;
  localparam logic [FIELD_W-1:0] FLD_IN_CH       = 3'd2;
  localparam logic [FIELD_W-1:0] FLD_OUT_CH      = 3'd3;
  localparam logic [FIELD_W-1:0] FLD_COMP        = 3'd4;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_BAD_NUM = 2'd2,
    ERR_ABORTED = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] bias_addr;
    logic [DATA_W-1:0] weight_addr;
    logic [DATA_W-1:0] in_ch;
    logic [DATA_W-1:0] out_ch;
    logic [DATA_W-1:0] compensation;
  } desc_t;

  // Command code issued for each of the three per-layer phases.
  function automatic logic [CMD_W-1:0] phase_cmd(input logic [1:0] phase);
    case (phase)
      2'd0:    return CMD_LOAD_BIAS;
      2'd1:    return CMD_LOAD_WEIGHT;
      default: return CMD_RUN_LAYER;
    endcase
  endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Bus between the register block/datapath (master) and the sequencer (slave).
interface nn_layer_sequencer_if #(
  parameter int unsigned LW = 3
);

  logic          desc_we;
  logic [LW-1:0] desc_idx;
  logic [2:0]    desc_field;
  logic [31:0]   desc_wdata;
  logic [LW:0]   num_layers;
  logic          start;
  logic          abort;
  logic          cmd_done;

  logic [7:0]    cmd;
  logic [31:0]   bias_addr;
  logic [31:0]   weight_addr;
  logic [31:0]   in_ch;
  logic [31:0]   out_ch;
  logic [31:0]   compensation;
  logic [31:0]   layer;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  modport master (
    output desc_we, desc_idx, desc_field, desc_wdata, num_layers, start, abort, cmd_done,
    input  cmd, bias_addr, weight_addr, in_ch, out_ch, compensation, layer,
    input  busy, done, err, err_code
  );

  modport slave (
    input  desc_we, desc_idx, desc_field, desc_wdata, num_layers, start, abort, cmd_done,
    output cmd, bias_addr, weight_addr, in_ch, out_ch, compensation, layer,
    output busy, done, err, err_code
  );

endinterface

// File: rtl/nn_desc_table.sv
// Per-layer descriptor register file: field-wise synchronous write,
// asynchronous whole-entry read.
module nn_desc_table
  import nn_layer_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LAYERS = 8,
  parameter int unsigned LW         = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_we,
  input  logic [LW-1:0]      i_idx,
  input  logic [FIELD_W-1:0] i_field,
  input  logic [DATA_W-1:0]  i_wdata,
  input  logic [LW-1:0]      i_rd_idx,
  output desc_t              o_entry_c
);

  desc_t r_mem [MAX_LAYERS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(MAX_LAYERS); i++) r_mem[i] <= '0;
    end else if (i_we && (32'(i_idx) < MAX_LAYERS)) begin
      case (i_field)
        FLD_BIAS_ADDR:   r_mem[i_idx].bias_addr    <= i_wdata;
        FLD_WEIGHT_ADDR: r_mem[i_idx].weight_addr  <= i_wdata;
        FLD_IN_CH:       r_mem[i_idx].in_ch        <= i_wdata;
        FLD_OUT_CH:      r_mem[i_idx].out_ch       <= i_wdata;
        FLD_COMP:        r_mem[i_idx].compensation <= i_wdata;
        default:         ;
      endcase
    end
  end

  assign o_entry_c = r_mem[i_rd_idx];

endmodule

// File: rtl/nn_layer_sequencer.sv
// Walks the descriptor table layer by layer, issuing bias/weight/run command
// pulses to the NN datapath and waiting for its done handshake after each.
module nn_layer_sequencer
  import nn_layer_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LAYERS     = 8,
  parameter int unsigned LW             = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  nn_layer_sequencer_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  state_e          r_state,     w_state;
  logic [LW-1:0]   r_layer,     w_layer;
  logic [1:0]      r_phase,     w_phase;
  logic [LW:0]     r_num,       w_num;
  logic [TW-1:0]   r_tmo,       w_tmo;
  desc_t           r_cfg,       w_cfg;
  logic [LW-1:0]   r_layer_out, w_layer_out;
  logic [CMD_W-1:0] r_cmd,      w_cmd;
  logic            r_busy,      w_busy;
  logic            r_done,      w_done;
  logic            r_err,       w_err;
  err_code_e       r_err_code,  w_err_code;
  desc_t           w_entry;

  nn_desc_table #(
    .MAX_LAYERS (MAX_LAYERS),
    .LW         (LW)
  ) u_desc_table (
    .i_clk     (HCLK),
    .i_rst_n   (HRESETn),
    .i_we      (bus.desc_we),
    .i_idx     (bus.desc_idx),
    .i_field   (bus.desc_field),
    .i_wdata   (bus.desc_wdata),
    .i_rd_idx  (r_layer),
    .o_entry_c (w_entry)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_layer     <= '0;
      r_phase     <= '0;
      r_num       <= '0;
      r_tmo       <= '0;
      r_cfg       <= '0;
      r_layer_out <= '0;
      r_cmd       <= CMD_NONE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_state     <= w_state;
      r_layer     <= w_layer;
      r_phase     <= w_phase;
      r_num       <= w_num;
      r_tmo       <= w_tmo;
      r_cfg       <= w_cfg;
      r_layer_out <= w_layer_out;
      r_cmd       <= w_cmd;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_err       <= w_err;
      r_err_code  <= w_err_code;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_layer     = r_layer;
    w_phase     = r_phase;
    w_num       = r_num;
    w_tmo       = r_tmo;
    w_cfg       = r_cfg;
    w_layer_out = r_layer_out;
    w_cmd       = CMD_NONE;
    w_done      = 1'b0;
    w_err       = r_err;
    w_err_code  = r_err_code;

    // Abort preempts every active state, including a pending cmd pulse.
    if ((r_state != ST_IDLE) && bus.abort) begin
      w_state    = ST_IDLE;
      w_err      = 1'b1;
      w_err_code = ERR_ABORTED;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            w_err      = 1'b0;
            w_err_code = ERR_NONE;
            w_num      = bus.num_layers;
            if (bus.num_layers == '0) begin
              w_state = ST_FIN;
            end else if (bus.num_layers > (LW+1)'(MAX_LAYERS)) begin
              w_err      = 1'b1;
              w_err_code = ERR_BAD_NUM;
            end else begin
              w_state = ST_LOAD;
              w_layer = '0;
              w_phase = '0;
            end
          end
        end
        ST_LOAD: begin
          w_cfg       = w_entry;
          w_layer_out = r_layer;
          w_state     = ST_ISSUE;
        end
        ST_ISSUE: begin
          w_cmd   = phase_cmd(r_phase);
          w_tmo   = '0;
          w_state = ST_WAIT;
        end
        ST_WAIT: begin
          w_tmo = r_tmo + TW'(1);
          // cmd_done takes priority over a coincident timeout expiry.
          if (bus.cmd_done) begin
            if (r_phase != 2'd2) begin
              w_phase = r_phase + 2'd1;
              w_state = ST_ISSUE;
            end else if (((LW+1)'(r_layer) + (LW+1)'(1)) < r_num) begin
              w_layer = r_layer + LW'(1);
              w_phase = '0;
              w_state = ST_LOAD;
            end else begin
              w_state = ST_FIN;
            end
          end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            w_state    = ST_IDLE;
            w_err      = 1'b1;
            w_err_code = ERR_TIMEOUT;
          end
        end
        ST_FIN: begin
          w_done  = 1'b1;
          w_state = ST_IDLE;
        end
        default: w_state = ST_IDLE;
      endcase
    end

    w_busy = (w_state != ST_IDLE);
  end

  assign bus.cmd          = r_cmd;
  assign bus.bias_addr    = r_cfg.bias_addr;
  assign bus.weight_addr  = r_cfg.weight_addr;
  assign bus.in_ch        = r_cfg.in_ch;
  assign bus.out_ch       = r_cfg.out_ch;
  assign bus.compensation = r_cfg.compensation;
  assign bus.layer        = 32'(r_layer_out);
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.err_code     = r_err_code;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed self-checking bench for nn_layer_sequencer (timeout shortened to 16).
module tb_nn_layer_sequencer;
  import nn_layer_sequencer_pkg::*;

  logic  HCLK;
  logic  HRESETn;
  int    checks   = 0;
  int    errors   = 0;
  int    done_cnt = 0;
  int    cmd_cnt  = 0;
  int    lat;
  int    snap;
  desc_t d0, d1, dz;

  nn_layer_sequencer_if #(.LW(3)) bus ();

  nn_layer_sequencer #(
    .MAX_LAYERS     (8),
    .LW             (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) begin
    if (bus.done) done_cnt++;
    if (bus.cmd != CMD_NONE) cmd_cnt++;
  end

  task automatic step();
    @(negedge HCLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [2:0] fld, input logic [31:0] data);
    bus.desc_we = 1'b1; bus.desc_idx = idx; bus.desc_field = fld; bus.desc_wdata = data;
    step();
    bus.desc_we = 1'b0;
  endtask

  task automatic wr_entry(input logic [2:0] idx, input desc_t d);
    wr(idx, FLD_BIAS_ADDR,   d.bias_addr);
    wr(idx, FLD_WEIGHT_ADDR, d.weight_addr);
    wr(idx, FLD_IN_CH,       d.in_ch);
    wr(idx, FLD_OUT_CH,      d.out_ch);
    wr(idx, FLD_COMP,        d.compensation);
  endtask

  task automatic pulse_start(input logic [3:0] n);
    bus.num_layers = n; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Bounded wait for the next cmd pulse; returns cycles elapsed.
  task automatic wait_cmd(output int l);
    l = 0;
    do begin step(); l++; end while (bus.cmd == CMD_NONE && l < 40);
  endtask

  // Return cmd_done so it is sampled n edges after the cmd pulse appeared.
  task automatic respond(input int n);
    repeat (n - 1) step();
    bus.cmd_done = 1'b1;
    step();
    bus.cmd_done = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] exp_cmd, input int exp_lat,
                         input desc_t d, input int exp_layer);
    int l;
    wait_cmd(l);
    chk({tag, "_cmd"}, 32'(bus.cmd), 32'(exp_cmd));
    chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
    chk({tag, "_bias"}, bus.bias_addr, d.bias_addr);
    chk({tag, "_weight"}, bus.weight_addr, d.weight_addr);
    chk({tag, "_inch"}, bus.in_ch, d.in_ch);
    chk({tag, "_outch"}, bus.out_ch, d.out_ch);
    chk({tag, "_comp"}, bus.compensation, d.compensation);
    chk({tag, "_layer"}, bus.layer, 32'(exp_layer));
  endtask

  // Called right after the last cmd_done was sampled: done follows one cycle later.
  task automatic finish_run(input string tag);
    int dc;
    dc = done_cnt;
    chk({tag, "_done_pre"}, 32'(bus.done), 32'd0);
    step();
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
    step();
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(dc + 1));
  endtask

  initial begin
    HRESETn = 1'b0;
    bus.desc_we = 1'b0; bus.desc_idx = '0; bus.desc_field = '0; bus.desc_wdata = '0;
    bus.num_layers = '0; bus.start = 1'b0; bus.abort = 1'b0; bus.cmd_done = 1'b0;
    d0 = '{bias_addr: 32'h100, weight_addr: 32'h200, in_ch: 32'd16, out_ch: 32'd32, compensation: 32'd7};
    d1 = '{bias_addr: 32'h300, weight_addr: 32'h400, in_ch: 32'd32, out_ch: 32'd8, compensation: 32'd9};
    dz = '0;
    step(); step();
    chk("rst_cmd", 32'(bus.cmd), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_err", {31'd0, bus.err}, 32'h0);
    chk("rst_errcode", 32'(bus.err_code), 32'h0);
    chk("rst_bias", bus.bias_addr, 32'h0);
    chk("rst_layer", bus.layer, 32'h0);
    HRESETn = 1'b1;
    step();

    // Normal two-layer run
    wr_entry(3'd0, d0);
    wr_entry(3'd1, d1);
    pulse_start(4'd2);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    run_cmd("t1_l0_b", CMD_LOAD_BIAS,   2, d0, 0); respond(5);
    run_cmd("t1_l0_w", CMD_LOAD_WEIGHT, 1, d0, 0); respond(5);
    run_cmd("t1_l0_r", CMD_RUN_LAYER,   1, d0, 0); respond(5);
    run_cmd("t1_l1_b", CMD_LOAD_BIAS,   2, d1, 1); respond(5);
    run_cmd("t1_l1_w", CMD_LOAD_WEIGHT, 1, d1, 1); respond(5);
    run_cmd("t1_l1_r", CMD_RUN_LAYER,   1, d1, 1); respond(5);
    finish_run("t1");
    chk("t1_err", 32'(bus.err), 32'd0);

    // Descriptor writes mid-run and a start pulse while busy
    pulse_start(4'd2);
    run_cmd("t2_l0_b", CMD_LOAD_BIAS, 2, d0, 0);
    wr(3'd1, FLD_BIAS_ADDR, 32'hABC);
    wr(3'd0, FLD_BIAS_ADDR, 32'hDEAD);
    bus.num_layers = 4'd1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t2_l0_stable", bus.bias_addr, 32'h100);
    respond(2);
    run_cmd("t2_l0_w", CMD_LOAD_WEIGHT, 1, d0, 0); respond(5);
    run_cmd("t2_l0_r", CMD_RUN_LAYER,   1, d0, 0); respond(5);
    d1.bias_addr = 32'hABC;
    d0.bias_addr = 32'hDEAD;
    run_cmd("t2_l1_b", CMD_LOAD_BIAS,   2, d1, 1); respond(5);
    run_cmd("t2_l1_w", CMD_LOAD_WEIGHT, 1, d1, 1); respond(5);
    run_cmd("t2_l1_r", CMD_RUN_LAYER,   1, d1, 1); respond(5);
    finish_run("t2");

    // Zero layers: straight to FIN, no commands
    snap = cmd_cnt;
    pulse_start(4'd0);
    chk("t3_busy", 32'(bus.busy), 32'd1);
    finish_run("t3");
    chk("t3_err", 32'(bus.err), 32'd0);
    chk("t3_no_cmd", 32'(cmd_cnt), 32'(snap));

    // Too many layers
    pulse_start(4'd9);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_err", 32'(bus.err), 32'd1);
    chk("t4_errcode", 32'(bus.err_code), 32'd2);
    step();
    chk("t4_busy2", 32'(bus.busy), 32'd0);

    // Timeout: no cmd_done, expiry 16 cycles after the cmd
    pulse_start(4'd1);
    chk("t5_err_clr", 32'(bus.err), 32'd0);
    run_cmd("t5_b", CMD_LOAD_BIAS, 2, d0, 0);
    repeat (15) step();
    chk("t5_err_pre", 32'(bus.err), 32'd0);
    chk("t5_busy_pre", 32'(bus.busy), 32'd1);
    step();
    chk("t5_err", 32'(bus.err), 32'd1);
    chk("t5_errcode", 32'(bus.err_code), 32'd1);
    chk("t5_busy", 32'(bus.busy), 32'd0);

    // cmd_done coincident with expiry continues the run
    pulse_start(4'd1);
    run_cmd("t5b_b", CMD_LOAD_BIAS, 2, d0, 0); respond(16);
    chk("t5b_err", 32'(bus.err), 32'd0);
    run_cmd("t5b_w", CMD_LOAD_WEIGHT, 1, d0, 0); respond(5);
    run_cmd("t5b_r", CMD_RUN_LAYER,   1, d0, 0); respond(5);
    finish_run("t5b");

    // Abort in WAIT at layer 1 phase 1, then a clean restart
    pulse_start(4'd2);
    run_cmd("t6_l0_b", CMD_LOAD_BIAS,   2, d0, 0); respond(5);
    run_cmd("t6_l0_w", CMD_LOAD_WEIGHT, 1, d0, 0); respond(5);
    run_cmd("t6_l0_r", CMD_RUN_LAYER,   1, d0, 0); respond(5);
    run_cmd("t6_l1_b", CMD_LOAD_BIAS,   2, d1, 1); respond(5);
    run_cmd("t6_l1_w", CMD_LOAD_WEIGHT, 1, d1, 1);
    step();
    snap = done_cnt;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_cmd", 32'(bus.cmd), 32'd0);
    chk("t6_err", 32'(bus.err), 32'd1);
    chk("t6_errcode", 32'(bus.err_code), 32'd3);
    repeat (3) step();
    chk("t6_no_done", 32'(done_cnt), 32'(snap));
    pulse_start(4'd1);
    chk("t6_err_clr", 32'(bus.err), 32'd0);
    run_cmd("t6r_b", CMD_LOAD_BIAS,   2, d0, 0); respond(5);
    run_cmd("t6r_w", CMD_LOAD_WEIGHT, 1, d0, 0); respond(5);
    run_cmd("t6r_r", CMD_RUN_LAYER,   1, d0, 0); respond(5);
    finish_run("t6r");

    // Abort in IDLE does nothing
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t7_err", 32'(bus.err), 32'd0);
    chk("t7_errcode", 32'(bus.err_code), 32'd0);

    // Asynchronous reset mid-run clears outputs and the table
    pulse_start(4'd2);
    run_cmd("t8_b", CMD_LOAD_BIAS, 2, d0, 0);
    #2 HRESETn = 1'b0;
    #1;
    chk("t8_busy", 32'(bus.busy), 32'd0);
    chk("t8_cmd", 32'(bus.cmd), 32'd0);
    chk("t8_bias", bus.bias_addr, 32'h0);
    step();
    HRESETn = 1'b1;
    step();
    pulse_start(4'd1);
    run_cmd("t8_tbl", CMD_LOAD_BIAS, 2, dz, 0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t8_abort", 32'(bus.err_code), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
